// File: rtl/kogge_stone_pipe.sv
// kogge_stone_pipe: pipelined Kogge-Stone adder/subtractor with stall-all valid/ready flow control
module kogge_stone_pipe #(
    parameter int WIDTH = 16,
    parameter int LPS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N = $clog2(WIDTH);
    localparam int S = (N + LPS - 1) / LPS;

    logic             advance, accept;
    logic [WIDTH-1:0] b_eff, p0, g_fin;
    logic [WIDTH-1:0] g_q [S];
    logic [WIDTH-1:0] g_d [S];
    logic [WIDTH-1:0] p_q [S];
    logic [WIDTH-1:0] p_d [S];
    logic [WIDTH-1:0] po_q [S];
    logic [WIDTH-1:0] po_d [S];
    logic             c0_q [S];
    logic             c0_d [S];
    logic             v_q [S];
    logic             v_d [S];
    logic [WIDTH-1:0] lg [S][LPS+1];
    logic [WIDTH-1:0] lp [S][LPS+1];
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, out_valid_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && !rst;
    assign accept   = in_valid && in_ready;

    assign b_eff   = b ^ {WIDTH{sub}};
    assign p0      = a ^ b_eff;
    assign c0_d[0] = cin ^ sub;
    assign p_d[0]  = p0;
    assign po_d[0] = p0;
    assign g_d[0]  = (a & b_eff) | {{(WIDTH-1){1'b0}}, p0[0] & c0_d[0]};
    assign v_d[0]  = accept;

    // Each stage applies up to LPS prefix levels to its registered (G, P) pair
    for (genvar s = 0; s < S; s++) begin : g_stage
        assign lg[s][0] = g_q[s];
        assign lp[s][0] = p_q[s];
        for (genvar j = 0; j < LPS; j++) begin : g_lvl
            localparam int K = s * LPS + j;
            if (K < N) begin : g_cell
                localparam int D = 1 << K;
                assign lg[s][j+1] = lg[s][j] | (lp[s][j] & (lg[s][j] << D));
                assign lp[s][j+1] = lp[s][j] & ((lp[s][j] << D) | {{(WIDTH-D){1'b0}}, {D{1'b1}}});
            end else begin : g_pass
                assign lg[s][j+1] = lg[s][j];
                assign lp[s][j+1] = lp[s][j];
            end
        end
        if (s > 0) begin : g_link
            assign g_d[s]  = lg[s-1][LPS];
            assign p_d[s]  = lp[s-1][LPS];
            assign po_d[s] = po_q[s-1];
            assign c0_d[s] = c0_q[s-1];
            assign v_d[s]  = v_q[s-1];
        end
    end

    // G[i] is the carry out of bit i, so it is also the carry into bit i+1
    assign g_fin  = lg[S-1][LPS];
    assign sum_d  = po_q[S-1] ^ {g_fin[WIDTH-2:0], c0_q[S-1]};
    assign cout_d = g_fin[WIDTH-1];
    assign ovf_d  = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '{default: 1'b0};
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            g_q         <= g_d;
            p_q         <= p_d;
            po_q        <= po_d;
            c0_q        <= c0_d;
            v_q         <= v_d;
            out_valid_q <= v_q[S-1];
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_kogge_stone_pipe.sv
// tb_kogge_stone_pipe: directed vectors, flow-control sequences and a randomized width/LPS sweep
module tb_kogge_stone_pipe;
    localparam int NC    = 12;
    localparam int BEATS = 10000;

    function automatic int cfg_w(int i);
        return i < 3 ? 16 : i < 6 ? 8 : i < 9 ? 32 : 64;
    endfunction

    function automatic int cfg_l(int i);
        int n;
        n = $clog2(cfg_w(i));
        return i % 3 == 0 ? 1 : i % 3 == 1 ? 2 : n;
    endfunction

    // Returns {ovf, cout, sum} from plain signed/unsigned arithmetic on the operand values
    function automatic logic [65:0] model(int w, logic [63:0] x, logic [63:0] y, logic ci, logic sb);
        logic signed [67:0] ux, uy, sx, sy, c, r, rs, top, lim;
        logic [65:0] res;
        ux  = 68'(x);
        uy  = 68'(y);
        c   = 68'(ci);
        lim = 68'sd1 <<< w;
        top = 68'sd1 <<< (w - 1);
        sx  = x[w-1] ? ux - lim : ux;
        sy  = y[w-1] ? uy - lim : uy;
        r   = sb ? ux - uy - c : ux + uy + c;
        rs  = sb ? sx - sy - c : sx + sy + c;
        res = '0;
        res[63:0] = 64'(r & (lim - 1));
        res[64]   = sb ? (r >= 0) : (r >= lim);
        res[65]   = (rs >= top) || (rs < -top);
        return res;
    endfunction

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic clk = 1'b0, rst = 1'b1, rst_s = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1, cout, ovf;
    logic [15:0] a = '0, b = '0, sum;
    logic [NC-1:0] sw_fin;

    kogge_stone_pipe #(.WIDTH(16), .LPS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        c, o;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("vec%0d_latency", idx), n, 5);
        chk($sformatf("vec%0d_sum", idx), sum, v.s);
        chk($sformatf("vec%0d_cout", idx), cout, v.c);
        chk($sformatf("vec%0d_ovf", idx), ovf, v.o);
    endtask

    initial begin
        vec_t        vt [11];
        logic [15:0] got [$];
        int          bi;
        vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4]  = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        vt[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[6]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vt[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[10] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", {ovf, cout, sum}, 0);
        rst = 1'b0;
        rst_s = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        foreach (vt[i]) run_vec(vt[i], i);

        bi = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c <= 8);
            in_valid = bi < 8; a = 16'(bi); b = 16'h0100; cin = 1'b0; sub = 1'b0;
            #1;
            chk($sformatf("bp_in_ready_c%0d", c), in_ready, (c < 6 || c > 8));
            if (out_valid && !out_ready) chk($sformatf("bp_hold_c%0d", c), sum, 16'h0100);
            if (out_valid && out_ready) got.push_back(sum);
            if (in_valid && in_ready) bi++;
        end
        in_valid = 1'b0;
        chk("bp_count", got.size(), 8);
        foreach (got[i]) chk($sformatf("bp_order%0d", i), got[i], 16'h0100 + i);

        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (c < 8) && (c % 2 == 0); a = 16'(c); b = 16'h0000;
            #1;
            if (c >= 5) chk($sformatf("bubble_c%0d", c), out_valid, (c - 5 < 8) && ((c - 5) % 2 == 0));
            if (c >= 5 && out_valid) chk($sformatf("bubble_sum_c%0d", c), sum, c - 5);
        end
        in_valid = 1'b0;

        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            rst = (c == 5);
            in_valid = (c <= 3) || (c == 6);
            a = (c == 6) ? 16'h1234 : 16'h0F0F; b = 16'h1111; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
            #1;
            if (c == 5) chk("mid_rst_in_ready", in_ready, 0);
            if (c == 6) chk("after_rst_in_ready", in_ready, 1);
            if (c == 6) chk("after_rst_outputs", {ovf, cout, sum}, 0);
            if (c >= 5) chk($sformatf("mid_rst_out_valid_c%0d", c), out_valid, c == 11);
            if (c == 11) chk("mid_rst_new_sum", sum, 16'h2345);
        end
        in_valid = 1'b0;

        for (int k = 0; k < 80000 && !(&sw_fin); k++) @(negedge clk);
        chk("sweep_finished", sw_fin, {NC{1'b1}});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    for (genvar g = 0; g < NC; g++) begin : sw
        localparam int W   = cfg_w(g);
        localparam int P   = cfg_l(g);
        localparam int LAT = ($clog2(W) + P - 1) / P + 1;
        logic         iv = 1'b0, ir, ov, orr = 1'b1, ci = 1'b0, sb = 1'b0, co, of, fin = 1'b0;
        logic [W-1:0] ra = '0, rb = '0, sm;
        assign sw_fin[g] = fin;

        kogge_stone_pipe #(.WIDTH(W), .LPS(P)) dut (
            .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(ci), .sub(sb),
            .out_valid(ov), .out_ready(orr),
            .sum(sm), .cout(co), .ovf(of)
        );

        initial begin
            logic [65:0] exp_q [$];
            logic [65:0] e, prev;
            int          n, sent, done;
            bit          stalled;
            wait (rst_s == 1'b0);
            @(negedge clk);
            iv = 1'b1; orr = 1'b1;
            ra = W'({$urandom(), $urandom()}); rb = W'({$urandom(), $urandom()});
            ci = 1'($urandom()); sb = 1'($urandom());
            e = model(W, 64'(ra), 64'(rb), ci, sb);
            @(negedge clk);
            iv = 1'b0;
            n = 1;
            while (!ov && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("sw%0d_latency", g), n, LAT);
            chk($sformatf("sw%0d_first", g), {of, co, 64'(sm)}, e);

            sent = 0; done = 0; stalled = 1'b0; prev = '0;
            for (int cyc = 0; cyc < 60000 && done < BEATS; cyc++) begin
                @(negedge clk);
                if (stalled) begin
                    chk($sformatf("sw%0d_hold_valid", g), ov, 1);
                    chk($sformatf("sw%0d_hold_data", g), {of, co, 64'(sm)}, prev);
                end
                orr = $urandom_range(0, 3) != 0;
                iv  = sent < BEATS && $urandom_range(0, 3) != 0;
                ra  = W'({$urandom(), $urandom()});
                rb  = W'({$urandom(), $urandom()});
                ci  = 1'($urandom());
                sb  = 1'($urandom());
                if ($urandom_range(0, 7) == 0) ra = '1;
                if ($urandom_range(0, 7) == 0) rb = W'(1) << (W - 1);
                #1;
                stalled = ov && !orr;
                prev = {of, co, 64'(sm)};
                if (ov && orr) begin
                    chk($sformatf("sw%0d_expected_beat", g), exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("sw%0d_beat%0d a=%0h b=%0h", g, done, 64'(ra), 64'(rb)), {of, co, 64'(sm)}, e);
                    end
                    done++;
                end
                if (iv && ir) begin
                    exp_q.push_back(model(W, 64'(ra), 64'(rb), ci, sb));
                    sent++;
                end
            end
            chk($sformatf("sw%0d_beats", g), done, BEATS);
            fin = 1'b1;
        end
    end
endmodule
